// File: rtl/apb5_pkg.sv
// Shared types and helpers for the APB5 completer memory.
//   apb_state_e : transfer FSM states
//   apb_resp_e  : response code reported on PBUSER
//   sec_state_e : security state decoded from {PNSE, PPROT[1]}
package apb5_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        RESP_OK        = 2'd0,
        RESP_UNALIGNED = 2'd1,
        RESP_PROT      = 2'd2,
        RESP_STRB      = 2'd3
    } apb_resp_e;

    typedef enum logic [1:0] {
        SEC_SECURE    = 2'b00,
        SEC_NONSECURE = 2'b01,
        SEC_ROOT      = 2'b10,
        SEC_REALM     = 2'b11
    } sec_state_e;

    // Decode the requester security state from {PNSE, PPROT[1]}.
    function automatic sec_state_e sec_decode(input logic nse, input logic prot1);
        sec_state_e s;
        case ({nse, prot1})
            2'b00:   s = SEC_SECURE;
            2'b01:   s = SEC_NONSECURE;
            2'b10:   s = SEC_ROOT;
            default: s = SEC_REALM;
        endcase
        return s;
    endfunction

    // Only secure and root requesters may touch the secure-only region.
    function automatic logic sec_region_ok(input sec_state_e s);
        return (s == SEC_SECURE) || (s == SEC_ROOT);
    endfunction

endpackage

// File: rtl/apb5_mem_array.sv
// Word array plus per-word tag array for the APB5 completer.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset (clears all words/tags)
//   we, widx          : write enable and word index
//   wdata, wstrb      : write data and byte-lane strobes (only strobed lanes change)
//   wtag              : tag written to the word whenever we=1, regardless of strobes
//   ridx, rdata, rtag : combinational read port
module apb5_mem_array #(
    parameter int DEPTH_BITS = 6,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [DEPTH_BITS-1:0]   widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [TAG_WIDTH-1:0]    wtag,
    input  logic [DEPTH_BITS-1:0]   ridx,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [TAG_WIDTH-1:0]    rtag
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_r [DEPTH];

    // Storage: clear on reset, byte-strobed data update and full tag update on write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
                tag_r[i] <= '0;
            end
        end else if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (wstrb[l]) begin
                    mem_r[widx][l*8 +: 8] <= wdata[l*8 +: 8];
                end
            end
            tag_r[widx] <= wtag;
        end
    end

    assign rdata = mem_r[ridx];
    assign rtag  = tag_r[ridx];

endmodule

// File: rtl/apb5_completer_mem.sv
// APB5 completer backed by a word memory with byte strobes, per-word user tags,
// a fixed number of wait states and secure-region protection checks.
// Ports:
//   PCLK, PRESETN        : clock, synchronous active-low reset
//   PSEL..PWUSER         : APB5 request (PAUSER accepted but unused)
//   PRDATA, PRUSER       : read data / stored tag, non-zero only in a good read's PREADY cycle
//   PREADY, PSLVERR      : registered completion and error, high for one cycle
//   PBUSER               : response code (apb_resp_e), zero-extended
//   wakeup_err           : sticky, set when PSEL rises without PWAKEUP now or one cycle earlier
module apb5_completer_mem
    import apb5_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int RME_SUPPORT     = 1,
    parameter int WAKEUP_SUPPORT  = 1,
    parameter int USER_REQ_WIDTH  = 8,
    parameter int USER_DATA_WIDTH = 16,
    parameter int USER_RESP_WIDTH = 8,
    parameter int WAIT_CYCLES     = 2,
    parameter logic [ADDR_WIDTH-1:0] SECURE_BASE = 8'hC0
) (
    input  logic                       PCLK,
    input  logic                       PRESETN,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic [ADDR_WIDTH-1:0]      PADDR,
    input  logic                       PWRITE,
    input  logic [DATA_WIDTH-1:0]      PWDATA,
    input  logic [DATA_WIDTH/8-1:0]    PSTRB,
    input  logic [2:0]                 PPROT,
    input  logic                       PNSE,
    input  logic                       PWAKEUP,
    input  logic [USER_REQ_WIDTH-1:0]  PAUSER,
    input  logic [USER_DATA_WIDTH-1:0] PWUSER,
    output logic [DATA_WIDTH-1:0]      PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic [USER_DATA_WIDTH-1:0] PRUSER,
    output logic [USER_RESP_WIDTH-1:0] PBUSER,
    output logic                       wakeup_err
);
    localparam int         IDX_W   = ADDR_WIDTH - 2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    apb_state_e state_r, state_nxt_s;
    logic [3:0] cnt_r, cnt_nxt_s;
    logic       latch_s, ready_set_s, commit_s;

    logic [ADDR_WIDTH-1:0]      addr_r;
    logic                       write_r;
    logic [DATA_WIDTH-1:0]      wdata_r;
    logic [DATA_WIDTH/8-1:0]    strb_r;
    logic                       prot1_r;
    logic                       nse_r;
    logic [USER_DATA_WIDTH-1:0] wuser_r;

    logic [DATA_WIDTH-1:0]      prdata_r;
    logic                       pready_r;
    logic                       pslverr_r;
    logic [USER_DATA_WIDTH-1:0] pruser_r;
    logic [USER_RESP_WIDTH-1:0] pbuser_r;
    logic                       wakeup_err_r;
    logic                       psel_q_r;
    logic                       pwakeup_q_r;

    logic [DATA_WIDTH-1:0]      mem_rdata_s;
    logic [USER_DATA_WIDTH-1:0] mem_rtag_s;
    apb_resp_e                  resp_s;
    logic                       sec_ok_s;
    logic                       wake_viol_s;
    logic                       unused_s;

    assign unused_s = ^{PAUSER, PPROT[2], PPROT[0]};

    // PNSE only participates when the RME extension is enabled.
    assign sec_ok_s = sec_region_ok(sec_decode((RME_SUPPORT != 0) ? nse_r : 1'b0, prot1_r));

    // Error priority: unaligned, then protection, then strobed read.
    always_comb begin
        resp_s = RESP_OK;
        if (addr_r[1:0] != 2'b00) begin
            resp_s = RESP_UNALIGNED;
        end else if ((addr_r >= SECURE_BASE) && !sec_ok_s) begin
            resp_s = RESP_PROT;
        end else if (!write_r && (strb_r != '0)) begin
            resp_s = RESP_STRB;
        end else begin
            resp_s = RESP_OK;
        end
    end

    // PWAKEUP must be high in the PSEL rising cycle or the one before it.
    assign wake_viol_s = (WAKEUP_SUPPORT != 0) && PSEL && !psel_q_r && !PWAKEUP && !pwakeup_q_r;

    // FSM state register.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; PREADY is scheduled one cycle ahead so the registered
    // output appears exactly WAIT_CYCLES+1 cycles after the first PENABLE cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        ready_set_s = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt_s = SETUP;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
                cnt_nxt_s   = WAIT_LD;
                ready_set_s = (WAIT_LD == 4'd0);
            end
            ACCESS: begin
                if (pready_r) begin
                    commit_s = write_r && (resp_s == RESP_OK);
                    if (PSEL && !PENABLE) begin
                        state_nxt_s = SETUP;
                        latch_s     = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (!PSEL) begin
                    state_nxt_s = IDLE;
                end else begin
                    if (cnt_r != 4'd0) begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    ready_set_s = (cnt_r <= 4'd1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Wait counter and request capture at the setup phase.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            write_r <= 1'b0;
            wdata_r <= '0;
            strb_r  <= '0;
            prot1_r <= 1'b0;
            nse_r   <= 1'b0;
            wuser_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if (latch_s) begin
                addr_r  <= PADDR;
                write_r <= PWRITE;
                wdata_r <= PWDATA;
                strb_r  <= PSTRB;
                prot1_r <= PPROT[1];
                nse_r   <= PNSE;
                wuser_r <= PWUSER;
            end
        end
    end

    // Registered response: all outputs are zero outside the single PREADY cycle.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            pbuser_r  <= '0;
            prdata_r  <= '0;
            pruser_r  <= '0;
        end else if (ready_set_s) begin
            pready_r  <= 1'b1;
            pslverr_r <= (resp_s != RESP_OK);
            pbuser_r  <= USER_RESP_WIDTH'(resp_s);
            prdata_r  <= (!write_r && (resp_s == RESP_OK)) ? mem_rdata_s : '0;
            pruser_r  <= (!write_r && (resp_s == RESP_OK)) ? mem_rtag_s  : '0;
        end else begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            pbuser_r  <= '0;
            prdata_r  <= '0;
            pruser_r  <= '0;
        end
    end

    // Sticky wakeup protocol flag and the PSEL/PWAKEUP history it needs.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            wakeup_err_r <= 1'b0;
            psel_q_r     <= 1'b0;
            pwakeup_q_r  <= 1'b0;
        end else begin
            wakeup_err_r <= wakeup_err_r | wake_viol_s;
            psel_q_r     <= PSEL;
            pwakeup_q_r  <= PWAKEUP;
        end
    end

    apb5_mem_array #(
        .DEPTH_BITS (IDX_W),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (USER_DATA_WIDTH)
    ) u_mem (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .we    (commit_s),
        .widx  (addr_r[ADDR_WIDTH-1:2]),
        .wdata (wdata_r),
        .wstrb (strb_r),
        .wtag  (wuser_r),
        .ridx  (addr_r[ADDR_WIDTH-1:2]),
        .rdata (mem_rdata_s),
        .rtag  (mem_rtag_s)
    );

    assign PRDATA     = prdata_r;
    assign PREADY     = pready_r;
    assign PSLVERR    = pslverr_r;
    assign PRUSER     = pruser_r;
    assign PBUSER     = pbuser_r;
    assign wakeup_err = wakeup_err_r;

endmodule

// File: tb/tb_apb5_completer_mem.sv
// Directed bench: one instance with 2 wait states, one with none, sharing the
// request bus. The "fast" selector picks which instance's response is observed.
module tb_apb5_completer_mem;
    import apb5_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        PSEL, PENABLE, PWRITE, PNSE, PWAKEUP;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [7:0]  PAUSER;
    logic [15:0] PWUSER;

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b, wkerr_a, wkerr_b;
    logic [15:0] pruser_a, pruser_b;
    logic [7:0]  pbuser_a, pbuser_b;

    logic        fast;
    logic        o_pready, o_pslverr;
    logic [31:0] o_prdata;
    logic [15:0] o_pruser;
    logic [7:0]  o_pbuser;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    assign o_pready  = fast ? pready_b  : pready_a;
    assign o_pslverr = fast ? pslverr_b : pslverr_a;
    assign o_prdata  = fast ? prdata_b  : prdata_a;
    assign o_pruser  = fast ? pruser_b  : pruser_a;
    assign o_pbuser  = fast ? pbuser_b  : pbuser_a;

    apb5_completer_mem #(.WAIT_CYCLES(2)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PNSE(PNSE), .PWAKEUP(PWAKEUP), .PAUSER(PAUSER),
        .PWUSER(PWUSER), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .PRUSER(pruser_a), .PBUSER(pbuser_a),
        .wakeup_err(wkerr_a)
    );

    apb5_completer_mem #(.WAIT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PNSE(PNSE), .PWAKEUP(PWAKEUP), .PAUSER(PAUSER),
        .PWUSER(PWUSER), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .PRUSER(pruser_b), .PBUSER(pbuser_b),
        .wakeup_err(wkerr_b)
    );

    // One full transfer; returns captured response and the number of PREADY-low
    // cycles from the first PENABLE cycle (40 means the bound expired).
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic prot1, input logic nse,
                        input logic [15:0] wu, output logic [31:0] rd, output logic [15:0] ru,
                        output logic err, output logic [7:0] bu, output int waits);
        logic done;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        PSTRB = strb; PPROT = {1'b0, prot1, 1'b0}; PNSE = nse; PWUSER = wu;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0; done = 1'b0;
        rd = 32'h0; ru = 16'h0; err = 1'b0; bu = 8'h0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            if (o_pready) begin
                rd = o_prdata; ru = o_pruser; err = o_pslverr; bu = o_pbuser;
                done = 1'b1;
            end else begin
                waits++;
                @(posedge PCLK); #1;
            end
        end
    endtask

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
            PSEL = 1'b0; PENABLE = 1'b0;
        end
    endtask

    task automatic test_reset();
        PRESETN = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({pready_a, pslverr_a, prdata_a, pruser_a, pbuser_a, wkerr_a} !== 58'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pready_a, pslverr_a, prdata_a, pruser_a, pbuser_a, wkerr_a});
        end
        @(posedge PCLK); #1;
        PRESETN = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic [15:0] ru; logic err; logic [7:0] bu; int w;
        fast = 1'b0;
        xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 16'h1234, rd, ru, err, bu, w);
        checks++;
        if (w !== 3) begin errors++; $display("FAIL basic_wr_latency: got %0d expected 3", w); end
        checks++;
        if ({err, bu} !== 9'h0) begin errors++; $display("FAIL basic_wr_resp: got %h expected 0", {err, bu}); end
        bus_idle(1);
        @(negedge PCLK);
        checks++;
        if (pready_a !== 1'b0) begin errors++; $display("FAIL basic_pready_one_cycle: got %b expected 0", pready_a); end
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if (w !== 3) begin errors++; $display("FAIL basic_rd_latency: got %0d expected 3", w); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata: got %h expected deadbeef", rd); end
        checks++;
        if (ru !== 16'h1234) begin errors++; $display("FAIL basic_ruser: got %h expected 1234", ru); end
        checks++;
        if ({err, bu} !== 9'h0) begin errors++; $display("FAIL basic_rd_resp: got %h expected 0", {err, bu}); end
        bus_idle(1);
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic [15:0] ru; logic err; logic [7:0] bu; int w;
        fast = 1'b0;
        xfer(1'b1, 8'h10, 32'h000000AA, 4'b0001, 1'b0, 1'b0, 16'h5678, rd, ru, err, bu, w);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_rdata: got %h expected deadbeaa", rd); end
        checks++;
        if (ru !== 16'h5678) begin errors++; $display("FAIL strobe_ruser: got %h expected 5678", ru); end
        xfer(1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 16'h9ABC, rd, ru, err, bu, w);
        checks++;
        if ({err, bu} !== 9'h0) begin errors++; $display("FAIL zero_strb_resp: got %h expected 0", {err, bu}); end
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({rd, ru} !== {32'hDEADBEAA, 16'h9ABC}) begin
            errors++; $display("FAIL zero_strb_readback: got %h expected deadbeaa9abc", {rd, ru});
        end
        bus_idle(1);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [15:0] ru; logic err; logic [7:0] bu; int w;
        fast = 1'b0;
        xfer(1'b0, 8'h12, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu, rd} !== {1'b1, 8'd1, 32'h0}) begin
            errors++; $display("FAIL unaligned_read: got %h expected 10100000000", {err, bu, rd});
        end
        xfer(1'b0, 8'h10, 32'h0, 4'h1, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu, rd, ru} !== {1'b1, 8'd3, 32'h0, 16'h0}) begin
            errors++; $display("FAIL strobed_read: got %h expected 103000000000000", {err, bu, rd, ru});
        end
        xfer(1'b1, 8'h11, 32'h11111111, 4'hF, 1'b0, 1'b0, 16'h7777, rd, ru, err, bu, w);
        checks++;
        if ({err, bu} !== {1'b1, 8'd1}) begin errors++; $display("FAIL unaligned_write: got %h expected 101", {err, bu}); end
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({rd, ru} !== {32'hDEADBEAA, 16'h9ABC}) begin
            errors++; $display("FAIL error_no_update: got %h expected deadbeaa9abc", {rd, ru});
        end
        bus_idle(1);
    endtask

    task automatic test_protection();
        logic [31:0] rd; logic [15:0] ru; logic err; logic [7:0] bu; int w;
        fast = 1'b0;
        xfer(1'b1, 8'hC4, 32'h11223344, 4'hF, 1'b1, 1'b0, 16'h4444, rd, ru, err, bu, w);
        checks++;
        if ({err, bu} !== {1'b1, 8'd2}) begin errors++; $display("FAIL prot_nonsecure_wr: got %h expected 102", {err, bu}); end
        xfer(1'b0, 8'hC4, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu, rd} !== 41'h0) begin errors++; $display("FAIL prot_blocked_readback: got %h expected 0", {err, bu, rd}); end
        xfer(1'b1, 8'hC4, 32'h11223344, 4'hF, 1'b0, 1'b0, 16'h4444, rd, ru, err, bu, w);
        checks++;
        if ({err, bu} !== 9'h0) begin errors++; $display("FAIL prot_secure_wr: got %h expected 0", {err, bu}); end
        xfer(1'b0, 8'hC4, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu, rd, ru} !== {9'h0, 32'h11223344, 16'h4444}) begin
            errors++; $display("FAIL prot_root_rd: got %h expected 000112233444444", {err, bu, rd, ru});
        end
        xfer(1'b0, 8'hC4, 32'h0, 4'h0, 1'b1, 1'b1, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu, rd} !== {1'b1, 8'd2, 32'h0}) begin
            errors++; $display("FAIL prot_realm_rd: got %h expected 10200000000", {err, bu, rd});
        end
        xfer(1'b0, 8'hC5, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu} !== {1'b1, 8'd1}) begin errors++; $display("FAIL prot_unaligned_priority: got %h expected 101", {err, bu}); end
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu, rd} !== {9'h0, 32'hDEADBEAA}) begin
            errors++; $display("FAIL prot_nonsecure_low: got %h expected 000deadbeaa", {err, bu, rd});
        end
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [15:0] ru; logic err; logic [7:0] bu;
        int w0, w1, w2, w3, w4, w5;
        fast = 1'b1;
        bus_idle(2);
        xfer(1'b1, 8'h00, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 16'h1111, rd, ru, err, bu, w0);
        xfer(1'b1, 8'h04, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0, 16'h2222, rd, ru, err, bu, w1);
        checks++;
        if ({w0, w1} !== {32'd1, 32'd1}) begin errors++; $display("FAIL b2b_wr_latency: got %0d %0d expected 1 1", w0, w1); end
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w2);
        checks++;
        if ({rd, ru} !== {32'hA5A5A5A5, 16'h1111}) begin errors++; $display("FAIL b2b_rd0: got %h expected a5a5a5a51111", {rd, ru}); end
        xfer(1'b0, 8'h04, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w3);
        checks++;
        if ({rd, ru} !== {32'h5A5A5A5A, 16'h2222}) begin errors++; $display("FAIL b2b_rd4: got %h expected 5a5a5a5a2222", {rd, ru}); end
        xfer(1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 16'h3333, rd, ru, err, bu, w4);
        xfer(1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w5);
        checks++;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_wr_then_rd: got %h expected cafef00d", rd); end
        checks++;
        if ({w2, w3, w4, w5} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            errors++; $display("FAIL b2b_rd_latency: got %0d %0d %0d %0d expected 1", w2, w3, w4, w5);
        end
        bus_idle(3);
        fast = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic [15:0] ru; logic err; logic [7:0] bu; int w;
        fast = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 32'h12345678;
        PSTRB = 4'hF; PPROT = 3'b000; PNSE = 1'b0; PWUSER = 16'h5555;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETN = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESETN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({pready_a, pslverr_a, prdata_a, pruser_a, pbuser_a} !== 57'h0) begin
            errors++; $display("FAIL midreset_outputs: got %h expected 0", {pready_a, pslverr_a, prdata_a, pruser_a, pbuser_a});
        end
        checks++;
        if (dut.state_r !== IDLE) begin errors++; $display("FAIL midreset_state: got %0d expected %0d", dut.state_r, IDLE); end
        xfer(1'b0, 8'h20, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({err, bu, rd, ru} !== 57'h0) begin errors++; $display("FAIL midreset_no_write: got %h expected 0", {err, bu, rd, ru}); end
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({rd, ru} !== 48'h0) begin errors++; $display("FAIL reset_clears_mem: got %h expected 0", {rd, ru}); end
        bus_idle(1);
    endtask

    task automatic test_wakeup();
        logic [31:0] rd; logic [15:0] ru; logic err; logic [7:0] bu; int w;
        fast = 1'b0;
        @(negedge PCLK);
        checks++;
        if (wkerr_a !== 1'b0) begin errors++; $display("FAIL wakeup_clean: got %b expected 0", wkerr_a); end
        PWAKEUP = 1'b0;
        bus_idle(2);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, rd, ru, err, bu, w);
        checks++;
        if ({w, err, bu} !== {32'd3, 9'h0}) begin errors++; $display("FAIL wakeup_xfer_normal: waits %0d resp %h expected 3 0", w, {err, bu}); end
        checks++;
        if (wkerr_a !== 1'b1) begin errors++; $display("FAIL wakeup_set: got %b expected 1", wkerr_a); end
        PWAKEUP = 1'b1;
        bus_idle(4);
        @(negedge PCLK);
        checks++;
        if (wkerr_a !== 1'b1) begin errors++; $display("FAIL wakeup_sticky: got %b expected 1", wkerr_a); end
        test_reset();
        @(negedge PCLK);
        checks++;
        if (wkerr_a !== 1'b0) begin errors++; $display("FAIL wakeup_reset_clear: got %b expected 0", wkerr_a); end
    endtask

    initial begin
        fast = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0; PWDATA = 32'h0;
        PSTRB = 4'h0; PPROT = 3'b000; PNSE = 1'b0; PWAKEUP = 1'b1; PAUSER = 8'h5A;
        PWUSER = 16'h0; PRESETN = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_errors();
        test_protection();
        test_back_to_back();
        test_reset_mid_access();
        test_wakeup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
